mux_32bit: RTL and testbench
============================

// Module: mux_32bit
// PURPOSE
//  Registered 8:1 multiplexer of 32-bit words, the result-select stage of the 32-bit ALU.
//  Three select bits choose one of eight operation results (I0..I7).
//  The chosen word is captured on the clock edge and driven on out.
// PARAMETERS
//  WIDTH  32  data width of each input word and of out
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst_n  in   1      synchronous, active-low reset (sampled on rising clk edge)
//  out    out  WIDTH  registered selected word
//  I0..I7 in   WIDTH  eight candidate words, I0 = select 0 ... I7 = select 7
//  S1     in   1      select MSB
//  S2     in   1      select middle bit
//  S3     in   1      select LSB
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst_n is synchronous and active-low.
//  - sel = {S1,S2,S3}; unsigned 0..7 picks I[sel] (e.g. S1=0,S2=0,S3=1 -> I1).
//  - Combinational select, then one output register: latency exactly 1 clk.
//    out(n+1) = I[sel](n) at each rising edge while rst_n=1.
//  - Reset: rst_n=0 at a rising edge -> out = 0 (all WIDTH bits) on that edge.
//    Reset has priority over data; deasserted reset takes effect at the next edge.
//  - Before the first clock edge out is X in simulation; no async behaviour.
//  - Reset mid-stream: the pending selection is discarded; out=0 until the first
//    edge with rst_n=1, which loads I[sel] sampled at that edge.
//  - Selects and data changing together are sampled together; no glitch visible on out.
//  - Unknown/X on any select bit: out undefined in simulation.
//    Synthesis treats all 8 codes as valid; there is no illegal code.
//  - No handshake, no enable: the register loads every cycle.
//  - Bitwise independent: bit k of out depends only on bit k of the inputs.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - ALU_W = 32;
//    - select code localparams SEL_I0..SEL_I7 = 3'd0..3'd7.
//  - Sub-module mux2_32bit (2:1 mux of WIDTH bits, select s: 0->a, 1->b).
//    Instantiated 7 times as a tree:
//    - level 1 uses S3: pairs (I0,I1), (I2,I3), (I4,I5), (I6,I7);
//    - level 2 uses S2;
//    - level 3 uses S1.
//  - Output register in mux_32bit with synchronous clear.
// TESTING
//  1. rst_n=0 for 2 edges, all I = 32'hFFFFFFFF
//     -> out = 32'h00000000 after the first edge.
//  2. rst_n=1, I1=32'hFFFFFFFF, others 0, {S1,S2,S3}=001
//     -> out = 32'hFFFFFFFF one edge later, not the same cycle.
//  3. Ik = 32'h1111_1111*k, sweep sel 0..7, one per cycle
//     -> out = I[sel] from the previous cycle each edge; every code exercised.
//  4. Walking-1 on I5 (bit 0..31), sel=101
//     -> out equals I5 bit-for-bit; other inputs' toggling does not affect out.
//  5. sel=111 with I7=32'hA5A5A5A5 steady, assert rst_n=0 for 1 edge, then release
//     -> out = 0 for that edge, then 32'hA5A5A5A5 on the next edge.
//  6. Change sel 010 -> 110 and I2/I6 between edges
//     -> out reflects only the values sampled at each edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width and result-select codes
package alu_pkg;

  localparam int ALU_W = 32;

  // Result-select codes, sel = {S1,S2,S3}
  localparam logic [2:0] SEL_I0 = 3'd0;
  localparam logic [2:0] SEL_I1 = 3'd1;
  localparam logic [2:0] SEL_I2 = 3'd2;
  localparam logic [2:0] SEL_I3 = 3'd3;
  localparam logic [2:0] SEL_I4 = 3'd4;
  localparam logic [2:0] SEL_I5 = 3'd5;
  localparam logic [2:0] SEL_I6 = 3'd6;
  localparam logic [2:0] SEL_I7 = 3'd7;

endpackage

// File: rtl/mux_32bit_if.sv
// rtl/mux_32bit_if.sv - bundle of the result-select stage data/select/output signals
interface mux_32bit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
);

  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I3;
  logic [WIDTH-1:0] I4;
  logic [WIDTH-1:0] I5;
  logic [WIDTH-1:0] I6;
  logic [WIDTH-1:0] I7;
  logic             S1;
  logic             S2;
  logic             S3;
  logic [WIDTH-1:0] out;

  // Producer of operation results and selects, consumer of the chosen word
  modport master (
    output I0, I1, I2, I3, I4, I5, I6, I7,
    output S1, S2, S3,
    input  out
  );

  // The select stage itself
  modport slave (
    input  I0, I1, I2, I3, I4, I5, I6, I7,
    input  S1, S2, S3,
    output out
  );

endinterface

// File: rtl/mux2_32bit.sv
// rtl/mux2_32bit.sv - 2:1 word multiplexer, one node of the select tree
module mux2_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // s=0 passes a, s=1 passes b
  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/mux_32bit.sv
// rtl/mux_32bit.sv - registered 8:1 result-select stage of the 32-bit ALU
module mux_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] l1_01, l1_23, l1_45, l1_67;
  logic [WIDTH-1:0] l2_03, l2_47;
  logic [WIDTH-1:0] l3_07;
  logic [WIDTH-1:0] out_d, out_q;

  // Level 1: LSB picks within each adjacent pair
  mux2_32bit #(.WIDTH(WIDTH)) u_l1_01 (.a(I0), .b(I1), .s(S3), .y(l1_01));
  mux2_32bit #(.WIDTH(WIDTH)) u_l1_23 (.a(I2), .b(I3), .s(S3), .y(l1_23));
  mux2_32bit #(.WIDTH(WIDTH)) u_l1_45 (.a(I4), .b(I5), .s(S3), .y(l1_45));
  mux2_32bit #(.WIDTH(WIDTH)) u_l1_67 (.a(I6), .b(I7), .s(S3), .y(l1_67));

  // Level 2: middle bit picks within each half
  mux2_32bit #(.WIDTH(WIDTH)) u_l2_03 (.a(l1_01), .b(l1_23), .s(S2), .y(l2_03));
  mux2_32bit #(.WIDTH(WIDTH)) u_l2_47 (.a(l1_45), .b(l1_67), .s(S2), .y(l2_47));

  // Level 3: MSB picks the half
  mux2_32bit #(.WIDTH(WIDTH)) u_l3_07 (.a(l2_03), .b(l2_47), .s(S1), .y(l3_07));

  // Next output word is the tree result; register loads every cycle
  always_comb begin
    out_d = l3_07;
  end

  // Output register with synchronous clear; clear wins over data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux_32bit.sv
// tb/tb_mux_32bit.sv - self-checking bench for the registered 8:1 select stage
module tb_mux_32bit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] din [8];
  logic [2:0]  sel;

  int checks;
  int errors;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep [8];

  mux_32bit_if #(.WIDTH(ALU_W)) bus ();

  assign bus.I0 = din[0];
  assign bus.I1 = din[1];
  assign bus.I2 = din[2];
  assign bus.I3 = din[3];
  assign bus.I4 = din[4];
  assign bus.I5 = din[5];
  assign bus.I6 = din[6];
  assign bus.I7 = din[7];
  assign bus.S1 = sel[2];
  assign bus.S2 = sel[1];
  assign bus.S3 = sel[0];

  mux_32bit #(.WIDTH(ALU_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I0    (bus.I0),
    .I1    (bus.I1),
    .I2    (bus.I2),
    .I3    (bus.I3),
    .I4    (bus.I4),
    .I5    (bus.I5),
    .I6    (bus.I6),
    .I7    (bus.I7),
    .S1    (bus.S1),
    .S2    (bus.S2),
    .S3    (bus.S3),
    .out   (bus.out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h", name, act, req);
    end
  endtask

  // Push the reference result for the current inputs, clock once, then compare
  task automatic cycle(input string name);
    logic [31:0] e;
    e = rst_n ? din[sel] : 32'h0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_underflow"}, bus.out, 32'hDEAD_BEEF);
    end else begin
      check(name, bus.out, exp_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sel    = SEL_I0;
    for (int k = 0; k < 8; k++) din[k] = 32'hFFFF_FFFF;

    // 1. reset held for two edges with all-ones data
    @(negedge clk);
    cycle("reset_edge1");
    cycle("reset_edge2");

    // 2. single-cycle latency: no change before the edge, value after
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = 32'h0;
    din[1] = 32'hFFFF_FFFF;
    sel    = SEL_I1;
    #2;
    check("latency_same_cycle", bus.out, 32'h0);
    cycle("latency_next_edge");

    // 3. sweep every select code over distinct words
    for (int k = 0; k < 8; k++) din[k] = 32'h1111_1111 * k;
    for (int k = 0; k < 8; k++) begin
      sweep[k].sel = 3'(k);
      sweep[k].exp = 32'h1111_1111 * k;
    end
    for (int v = 0; v < 8; v++) begin
      sel = sweep[v].sel;
      exp_q.push_back(sweep[v].exp);
      @(posedge clk);
      #1;
      check($sformatf("sweep_sel%0d", v), bus.out, exp_q.pop_front());
    end

    // 4. walking one on I5 while the other inputs churn
    sel = SEL_I5;
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < 8; k++) if (k != 5) din[k] = $urandom;
      din[5] = 32'h1 << b;
      cycle($sformatf("walk_bit%0d", b));
    end

    // 5. mid-stream reset with I7 steady
    sel    = SEL_I7;
    din[7] = 32'hA5A5_A5A5;
    cycle("pre_reset");
    rst_n = 1'b0;
    cycle("mid_reset");
    rst_n = 1'b1;
    cycle("post_reset");

    // 6. select and data change together between edges
    sel    = SEL_I2;
    din[2] = 32'h2222_0001;
    din[6] = 32'h6666_0001;
    cycle("sel010_first");
    sel    = SEL_I6;
    din[2] = 32'h2222_0002;
    din[6] = 32'h6666_0002;
    cycle("sel110_second");
    sel    = SEL_I2;
    din[2] = 32'h2222_0003;
    din[6] = 32'h6666_0003;
    cycle("sel010_third");

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
